// File: rtl/trigger_measure.sv
// Target-latency meter: counts target_tick strobes from a trigger rising edge
// to the next rising edge of the (asynchronous) target response line.
module trigger_measure #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             trigger,
   input  logic             target_event,
   input  logic             target_tick,
   input  logic             arm,
   input  logic [CNT_W-1:0] timeout,
   input  logic             set_timeout,
   output logic             busy,
   output logic             valid,
   output logic             timed_out,
   output logic [CNT_W-1:0] count
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_ARMED    = 2'd1,
      S_COUNTING = 2'd2,
      S_DONE     = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e                 state_q, state_d;
   logic                   trigger_q;
   logic [SYNC_STAGES-1:0] ev_sync_q;
   logic                   ev_q;
   logic [CNT_W-1:0]       timeout_q;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   busy_q, busy_d;
   logic                   valid_q, valid_d;
   logic                   timed_out_q, timed_out_d;

   logic                   ev_s;
   logic                   trig_rise;
   logic                   ev_rise;
   logic [CNT_W-1:0]       count_inc;
   logic                   limit_hit;

   // Input conditioning: trigger edge register, event synchroniser and edge register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         trigger_q <= 1'b0;
         ev_sync_q <= '0;
         ev_q      <= 1'b0;
      end else begin
         trigger_q <= trigger;
         ev_sync_q <= {ev_sync_q[SYNC_STAGES-2:0], target_event};
         ev_q      <= ev_s;
      end
   end

   assign ev_s      = ev_sync_q[SYNC_STAGES-1];
   assign trig_rise = trigger & ~trigger_q;
   assign ev_rise   = ev_s & ~ev_q;

   // Timeout register, usable from the cycle after it is written
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timeout_q <= '0;
      end else if (set_timeout) begin
         timeout_q <= timeout;
      end
   end

   // Equality on the incremented value: a timeout lowered below the count never matches
   assign count_inc = count_q + CNT_ONE;
   assign limit_hit = ((timeout_q != '0) && (count_inc == timeout_q)) ||
                      (count_inc == CNT_MAX);

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         count_q     <= '0;
         busy_q      <= 1'b0;
         valid_q     <= 1'b0;
         timed_out_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         busy_q      <= busy_d;
         valid_q     <= valid_d;
         timed_out_q <= timed_out_d;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      valid_d     = valid_q;
      timed_out_d = timed_out_q;

      case (state_q)
         S_IDLE: begin
            if (arm) begin
               state_d = S_ARMED;
            end
         end
         S_ARMED: begin
            if (trig_rise) begin
               state_d = S_COUNTING;
               count_d = '0;
            end
         end
         S_COUNTING: begin
            if (target_tick) begin
               count_d = count_inc;
            end
            // An event in the same cycle as the limit tick wins
            if (ev_rise) begin
               state_d     = S_DONE;
               valid_d     = 1'b1;
               timed_out_d = 1'b0;
            end else if (target_tick && limit_hit) begin
               state_d     = S_DONE;
               valid_d     = 1'b1;
               timed_out_d = 1'b1;
            end
         end
         S_DONE: begin
            if (arm) begin
               state_d     = S_ARMED;
               valid_d     = 1'b0;
               timed_out_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d == S_ARMED) || (state_d == S_COUNTING);
   end

   assign busy      = busy_q;
   assign valid     = valid_q;
   assign timed_out = timed_out_q;
   assign count     = count_q;

endmodule
